pe_alu_pipe: RTL

//  Parametrised, pipelined PE arithmetic unit replacing the fixed 32-bit per-op wrappers.

---
 rtl/pe_alu_pkg.sv | 26 ++
 rtl/pe_alu_core.sv | 42 ++++
 rtl/pe_alu_pipe.sv | 113 +++++++++++
 3 files changed

// File: rtl/pe_alu_pkg.sv
// Shared opcode definitions and legality check for the PE arithmetic unit.
// Optional feature macro: PE_ALU_MAC_EN (adds the multiply-accumulate opcode).
package pe_alu_pkg;

    localparam int OP_WIDTH = 4;

    localparam logic [OP_WIDTH-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_WIDTH-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_WIDTH-1:0] OP_MUX  = 4'd2;
    localparam logic [OP_WIDTH-1:0] OP_XOR  = 4'd3;
    localparam logic [OP_WIDTH-1:0] OP_MUL  = 4'd4;
    localparam logic [OP_WIDTH-1:0] OP_OR   = 4'd5;
    localparam logic [OP_WIDTH-1:0] OP_AND  = 4'd6;
    localparam logic [OP_WIDTH-1:0] OP_PASS = 4'd7;
    localparam logic [OP_WIDTH-1:0] OP_MAC  = 4'd8;

    // Opcodes are dense from zero, so legality is a single upper-bound compare.
    function automatic logic is_legal_op(input logic [OP_WIDTH-1:0] op);
`ifdef PE_ALU_MAC_EN
        return (op <= OP_MAC);
`else
        return (op <= OP_PASS);
`endif
    endfunction

endpackage

// File: rtl/pe_alu_core.sv
// Combinational datapath of the PE arithmetic unit: one result per operand set.
// Optional feature macro: PE_ALU_MAC_EN (adds the accumulator input and MAC opcode).
module pe_alu_core
    import pe_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  s,
    input  logic [OP_WIDTH-1:0]   op,
`ifdef PE_ALU_MAC_EN
    input  logic [DATA_WIDTH-1:0] acc_base,
`endif
    output logic [DATA_WIDTH-1:0] y,
    output logic                  legal
);

    logic [DATA_WIDTH-1:0] mul_lo;

    // Select the operation result; unsupported opcodes produce zero.
    always_comb begin
        mul_lo = a * b;
        legal  = is_legal_op(op);
        y      = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_MUX:  y = s ? b : a;
            OP_XOR:  y = a ^ b;
            OP_MUL:  y = mul_lo;
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            OP_PASS: y = a;
`ifdef PE_ALU_MAC_EN
            OP_MAC:  y = acc_base + mul_lo;
`endif
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/pe_alu_pipe.sv
// Pipelined PE arithmetic unit: computes at accept, then shifts the result
// through STAGES registers under a single global stall.
// Optional feature macro: PE_ALU_MAC_EN (multiply-accumulate with acc_clr).
module pe_alu_pipe
    import pe_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [OP_WIDTH-1:0]   cfg_op,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_s,
    input  logic                  acc_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic                  out_zero,
    output logic                  illegal_op
);

    logic                  adv;
    logic                  accept;
    logic [DATA_WIDTH-1:0] core_y;
    logic                  core_legal;

    logic [STAGES-1:0]     valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q [STAGES];
    logic [DATA_WIDTH-1:0] data_d [STAGES];
    logic                  illegal_q, illegal_d;

    assign adv      = ~valid_q[STAGES-1] | out_ready;
    assign in_ready = adv;
    assign accept   = in_valid & adv;

`ifdef PE_ALU_MAC_EN
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] acc_base;

    assign acc_base = acc_clr ? '0 : acc_q;

    // Accumulator takes the MAC result on accept; a lone acc_clr just zeroes it.
    always_comb begin
        acc_d = acc_q;
        if (accept && (cfg_op == OP_MAC)) begin
            acc_d = core_y;
        end else if (acc_clr) begin
            acc_d = '0;
        end
    end
`else
    logic unused_acc_clr;
    assign unused_acc_clr = acc_clr;
`endif

    pe_alu_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_core (
        .a        (in_a),
        .b        (in_b),
        .s        (in_s),
        .op       (cfg_op),
`ifdef PE_ALU_MAC_EN
        .acc_base (acc_base),
`endif
        .y        (core_y),
        .legal    (core_legal)
    );

    // Shift every stage together when the output is free; idle slots enter as bubbles.
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        illegal_d = illegal_q | (accept & ~core_legal);
        if (adv) begin
            valid_d[0] = accept;
            data_d[0]  = accept ? core_y : '0;
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    // Pipeline, sticky flag and accumulator registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            data_q    <= '{default: '0};
            illegal_q <= 1'b0;
`ifdef PE_ALU_MAC_EN
            acc_q     <= '0;
`endif
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            illegal_q <= illegal_d;
`ifdef PE_ALU_MAC_EN
            acc_q     <= acc_d;
`endif
        end
    end

    assign out_valid  = valid_q[STAGES-1];
    assign out_y      = data_q[STAGES-1];
    assign out_zero   = out_valid & (out_y == '0);
    assign illegal_op = illegal_q;

endmodule
